// File: rtl/avg_arb_pkg.sv
// Shared constants and record types for the averaging-pipeline arbiter.
// Tag and result ids are sized for the largest supported requester count (8).
package avg_arb_pkg;

    localparam int DATA_W   = 8;
    localparam int PIPE_LAT = 3;
    localparam int ID_MAX_W = 3;

    typedef struct packed {
        logic                valid;
        logic [ID_MAX_W-1:0] id;
    } tag_t;

    typedef struct packed {
        logic [ID_MAX_W-1:0] id;
        logic [DATA_W-1:0]   avg;
    } res_t;

endpackage

// File: rtl/avg_result_fifo.sv
// First-word-fall-through result buffer with occupancy count.
// Storage is cleared on reset so the head reads as zero when empty after reset.
module avg_result_fifo
    import avg_arb_pkg::*;
#(
    parameter int DEPTH = 5,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  res_t             wr_data,
    input  logic             pop,
    output res_t             rd_data,
    output logic             valid,
    output logic [CNT_W-1:0] count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    res_t             mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
        return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + 1'b1;
    endfunction

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    // NOTE: the storage array is reset along with the pointers; it is small, and this keeps the head at zero after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push) begin
                mem[wr_ptr] <= wr_data;
                wr_ptr      <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    assign rd_data = mem[rd_ptr];
    assign valid   = (count != '0);

endmodule

// File: rtl/avg_pipe_arbiter.sv
// Arbitrates N_REQ requesters onto a shared 3-stage averaging pipeline and returns tagged results in issue order.
// Define AVG_ARB_ROUND_ROBIN_EN for round-robin arbitration; otherwise the lowest index wins.
module avg_pipe_arbiter
    import avg_arb_pkg::*;
#(
    parameter int N_REQ      = 4,
    parameter int FIFO_DEPTH = 5,
    parameter int ID_W       = $clog2(N_REQ)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [N_REQ-1:0]        req_valid,
    output logic [N_REQ-1:0]        req_ready,
    input  logic [N_REQ*DATA_W-1:0] req_a,
    input  logic [N_REQ*DATA_W-1:0] req_b,
    input  logic [N_REQ*DATA_W-1:0] req_c,
    output logic [DATA_W-1:0]       pipe_a,
    output logic [DATA_W-1:0]       pipe_b,
    output logic [DATA_W-1:0]       pipe_c,
    input  logic [DATA_W-1:0]       pipe_avg,
    output logic                    res_valid,
    input  logic                    res_ready,
    output logic [ID_W-1:0]         res_id,
    output logic [DATA_W-1:0]       res_avg,
    output logic                    busy
);

    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    tag_t             tags [PIPE_LAT];
    logic [CNT_W-1:0] inflight;
    logic [CNT_W-1:0] fifo_count;
    logic             issue_ok;
    logic             grant_any;
    logic [ID_W-1:0]  grant_id;
    logic             transfer;
    int               scan_idx;
    res_t             fifo_out;

`ifdef AVG_ARB_ROUND_ROBIN_EN
    // Holds the index that gets first priority on the next arbitration.
    logic [ID_W-1:0] rr_ptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= '0;
        end else if (transfer) begin
            rr_ptr <= (int'(grant_id) == N_REQ - 1) ? '0 : grant_id + 1'b1;
        end
    end
`endif

    always_comb begin
        inflight = '0;
        for (int i = 0; i < PIPE_LAT; i++) begin
            inflight = inflight + CNT_W'(tags[i].valid);
        end
    end

    // Credit excludes this cycle's pop, keeping res_ready off the req_ready path.
    assign issue_ok = rst_n &&
        (({1'b0, inflight} + {1'b0, fifo_count}) < (CNT_W + 1)'(FIFO_DEPTH));

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        grant_any = 1'b0;
        grant_id  = '0;
        scan_idx  = 0;
        for (int k = 0; k < N_REQ; k++) begin
`ifdef AVG_ARB_ROUND_ROBIN_EN
            scan_idx = (int'(rr_ptr) + k) % N_REQ;
`else
            scan_idx = k;
`endif
            if (!grant_any && req_valid[scan_idx]) begin
                grant_any = 1'b1;
                grant_id  = ID_W'(scan_idx);
            end
        end
    end

    assign transfer = grant_any && issue_ok;

    always_comb begin
        req_ready = '0;
        pipe_a    = '0;
        pipe_b    = '0;
        pipe_c    = '0;
        if (transfer) begin
            req_ready[grant_id] = 1'b1;
            pipe_a = req_a[int'(grant_id)*DATA_W +: DATA_W];
            pipe_b = req_b[int'(grant_id)*DATA_W +: DATA_W];
            pipe_c = req_c[int'(grant_id)*DATA_W +: DATA_W];
        end
    end

    // The tag pipe mirrors the datapath latency; clearing it on reset hides stale pipeline output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < PIPE_LAT; i++) begin
                tags[i] <= '0;
            end
        end else begin
            tags[0] <= '{valid: transfer, id: ID_MAX_W'(grant_id)};
            for (int i = 1; i < PIPE_LAT; i++) begin
                tags[i] <= tags[i-1];
            end
        end
    end

    avg_result_fifo #(
        .DEPTH (FIFO_DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (tags[PIPE_LAT-1].valid),
        .wr_data ('{id: tags[PIPE_LAT-1].id, avg: pipe_avg}),
        .pop     (res_valid && res_ready),
        .rd_data (fifo_out),
        .valid   (res_valid),
        .count   (fifo_count)
    );

    assign res_id  = ID_W'(fifo_out.id);
    assign res_avg = fifo_out.avg;
    assign busy    = (inflight != '0) || res_valid;

endmodule

// File: tb/tb_avg_pipe_arbiter.sv
// Directed bench for avg_pipe_arbiter: models the external 3-stage averaging pipeline
// and checks latency, ordering, credit backpressure, reset flush and arbitration.
module tb_avg_pipe_arbiter;

    localparam int N_REQ      = 4;
    localparam int FIFO_DEPTH = 5;
    localparam int ID_W       = 2;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [N_REQ-1:0]     req_valid;
    logic [N_REQ-1:0]     req_ready;
    logic [N_REQ*8-1:0]   req_a, req_b, req_c;
    logic [7:0]           pipe_a, pipe_b, pipe_c, pipe_avg;
    logic                 res_valid, res_ready;
    logic [ID_W-1:0]      res_id;
    logic [7:0]           res_avg;
    logic                 busy;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    avg_pipe_arbiter #(
        .N_REQ      (N_REQ),
        .FIFO_DEPTH (FIFO_DEPTH),
        .ID_W       (ID_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_c     (req_c),
        .pipe_a    (pipe_a),
        .pipe_b    (pipe_b),
        .pipe_c    (pipe_c),
        .pipe_avg  (pipe_avg),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_id    (res_id),
        .res_avg   (res_avg),
        .busy      (busy)
    );

    // External averaging datapath: three register stages, never reset.
    logic [7:0] p0 = '0, p1 = '0, p2 = '0;
    always @(posedge clk) begin
        p0 <= 8'((10'(pipe_a) + 10'(pipe_b) + 10'(pipe_c)) / 10'd3);
        p1 <= p0;
        p2 <= p1;
    end
    assign pipe_avg = p2;

    typedef struct {
        int         req;
        logic [7:0] a, b, c;
        logic [7:0] exp_avg;
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_ops(input int i, input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
        req_a[8*i +: 8] = a;
        req_b[8*i +: 8] = b;
        req_c[8*i +: 8] = c;
    endtask

    task automatic drive_point();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        drive_point();
        req_valid = '0;
        res_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!busy) break;
        end
        check("drain_busy", busy, 0);
    endtask

    task automatic single_op(input vec_t v);
        drive_point();
        res_ready = 1'b1;
        set_ops(v.req, v.a, v.b, v.c);
        req_valid = N_REQ'(1) << v.req;
        @(negedge clk);
        check("single_grant", req_ready, N_REQ'(1) << v.req);
        check("single_pipe_a", pipe_a, v.a);
        drive_point();
        req_valid = '0;
        @(negedge clk);
        check("single_pipe_idle", pipe_a, 0);
        check("single_busy_inflight", busy, 1);
        repeat (2) begin
            @(negedge clk);
            check("single_early_valid", res_valid, 0);
        end
        @(negedge clk);
        check("single_res_valid", res_valid, 1);
        check("single_res_id", res_id, v.req);
        check("single_res_avg", res_avg, v.exp_avg);
        @(negedge clk);
        check("single_after_valid", res_valid, 0);
        check("single_after_busy", busy, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [N_REQ-1:0] exp_rdy;
        logic             xfer;
        int               n;

        vecs[0] = '{req: 0, a: 8'd10,  b: 8'd20,  c: 8'd30,  exp_avg: 8'd20};
        vecs[1] = '{req: 1, a: 8'd255, b: 8'd255, c: 8'd255, exp_avg: 8'd255};
        vecs[2] = '{req: 2, a: 8'd255, b: 8'd255, c: 8'd0,   exp_avg: 8'd170};
        vecs[3] = '{req: 3, a: 8'd1,   b: 8'd1,   c: 8'd0,   exp_avg: 8'd0};
        vecs[4] = '{req: 0, a: 8'd0,   b: 8'd0,   c: 8'd0,   exp_avg: 8'd0};
        vecs[5] = '{req: 3, a: 8'd7,   b: 8'd8,   c: 8'd9,   exp_avg: 8'd8};

        // Reset state, with a requester already asserting valid.
        rst_n     = 1'b0;
        req_valid = 4'b0001;
        res_ready = 1'b0;
        req_a = '1; req_b = '1; req_c = '1;
        @(negedge clk);
        check("rst_req_ready", req_ready, 0);
        check("rst_pipe_a", pipe_a, 0);
        check("rst_res_valid", res_valid, 0);
        check("rst_res_id", res_id, 0);
        check("rst_res_avg", res_avg, 0);
        check("rst_busy", busy, 0);
        drive_point();
        rst_n     = 1'b1;
        req_valid = '0;

`ifdef AVG_ARB_ROUND_ROBIN_EN
        // All requesters continuously valid: grants rotate and results follow in order.
        drive_point();
        res_ready = 1'b1;
        for (int i = 0; i < N_REQ; i++) set_ops(i, 8'(10*(i+1)), 8'(10*(i+1)), 8'(10*(i+1)));
        req_valid = '1;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (k < 8) check("rr_grant", req_ready, N_REQ'(1) << (k % N_REQ));
            if (k >= 4) begin
                check("rr_res_valid", res_valid, 1);
                check("rr_res_id", res_id, (k - 4) % N_REQ);
                check("rr_res_avg", res_avg, 10 * ((k - 4) % N_REQ + 1));
            end
            drive_point();
            if (k == 7) req_valid = '0;
        end
        drain();
`else
        // Fixed priority: requester 0 always wins over requester 2.
        drive_point();
        res_ready = 1'b1;
        set_ops(0, 8'd3, 8'd3, 8'd3);
        set_ops(2, 8'd6, 8'd6, 8'd6);
        req_valid = 4'b0101;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check("fp_grant_req0", req_ready, 4'b0001);
            drive_point();
        end
        req_valid = 4'b0100;
        @(negedge clk);
        check("fp_grant_req2", req_ready, 4'b0100);
        check("fp_pipe_a_req2", pipe_a, 6);
        drain();
`endif

        // Single operations and operand-width corners.
        for (int v = 0; v < 6; v++) begin
            single_op(vecs[v]);
        end

        // Backpressure: result consumer stalled, requester 1 streaming.
        drive_point();
        res_ready = 1'b0;
        n = 0;
        set_ops(1, 8'(3*n), 8'(3*n+1), 8'(3*n+2));
        req_valid = 4'b0010;
        for (int k = 0; k < 14; k++) begin
            @(negedge clk);
            exp_rdy = (k < FIFO_DEPTH || k == 9) ? 4'b0010 : 4'b0000;
            check("bp_ready", req_ready, exp_rdy);
            if (k >= 4) begin
                check("bp_res_valid", res_valid, 1);
                check("bp_res_id", res_id, 1);
                check("bp_res_avg", res_avg, (k >= 8) ? 3*(k-8)+1 : 1);
            end
            xfer = req_valid[1] && req_ready[1];
            drive_point();
            if (xfer) begin
                n++;
                set_ops(1, 8'(3*n), 8'(3*n+1), 8'(3*n+2));
            end
            if (k == 7) res_ready = 1'b1;
            if (k == 9) req_valid = '0;
        end
        check("bp_transfer_count", n, 6);
        drain();

        // Reset in the middle of two operations flushes both.
        drive_point();
        res_ready = 1'b1;
        set_ops(0, 8'd50, 8'd50, 8'd50);
        req_valid = 4'b0001;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            check("rmo_grant", req_ready, 4'b0001);
            drive_point();
        end
        req_valid = '0;
        rst_n     = 1'b0;
        @(negedge clk);
        check("rmo_busy_in_reset", busy, 0);
        check("rmo_valid_in_reset", res_valid, 0);
        drive_point();
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check("rmo_no_stale_result", res_valid, 0);
            check("rmo_busy_idle", busy, 0);
        end
        drive_point();
        for (int i = 0; i < N_REQ; i++) set_ops(i, 8'd1, 8'd2, 8'd3);
        req_valid = '1;
        @(negedge clk);
        check("rmo_first_grant", req_ready, 4'b0001);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
